pll_lock_ctrl: RTL and testbench

//   Initiator side of the PLL reset/lock interface. Runs on the 24 MHz refclk, drives the PLL

---
 rtl/pll_lock_ctrl_pkg.sv | 20 ++
 rtl/pll_lock_ctrl_sync_2ff.sv | 24 ++
 rtl/pll_lock_ctrl.sv | 115 +++++++++++
 tb/tb_pll_lock_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_ctrl_pkg.sv
// rtl/pll_lock_ctrl_pkg.sv - state encodings, default timing constants and width helper for pll_lock_ctrl
package pll_lock_ctrl_pkg;

    localparam logic [2:0] ST_RST_PLL   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam int DEF_RST_PULSE_CYC    = 48;
    localparam int DEF_LOCK_TIMEOUT_CYC = 24000;
    localparam int DEF_LOCK_STABLE_CYC  = 240;
    localparam int DEF_RETRY_MAX        = 3;

    // Counter width that holds 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// rtl/pll_lock_ctrl_sync_2ff.sv - generic 1-bit two-flop synchronizer with sync reset to 0
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL reset pulse, lock qualification, retry/fault and system reset release
module pll_lock_ctrl
    import pll_lock_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int RETRY_MAX        = DEF_RETRY_MAX
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       extlock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       locked,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int PW = cnt_w(RST_PULSE_CYC);
    localparam int TW = cnt_w(LOCK_TIMEOUT_CYC);
    localparam int SW = cnt_w(LOCK_STABLE_CYC);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [1:0]    RETRY_LAST = 2'(RETRY_MAX - 1);

    logic          lock_s;
    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [1:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          pll_reset_q, sys_rst_q, locked_q, fault_q;
    logic          qualify, timeout, lost, acquiring_q, acquiring_d;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (reset),
        .d_i   (extlock),
        .q_o   (lock_s)
    );

    assign acquiring_q = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
    assign acquiring_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE);
    assign qualify     = (state_q == ST_STABLE) && lock_s && (stab_q == STAB_LAST);
    // Qualification on the last allowed cycle beats the timeout.
    assign timeout     = acquiring_q && (tmo_q == TMO_LAST) && !qualify;
    assign lost        = (state_q == ST_RUN) && !lock_s;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST_PLL:   if (pulse_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (timeout)     state_d = (retry_q == RETRY_LAST) ? ST_FAULT : ST_RST_PLL;
                else if (lock_s) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (qualify)      state_d = ST_RUN;
                else if (timeout) state_d = (retry_q == RETRY_LAST) ? ST_FAULT : ST_RST_PLL;
                else if (!lock_s) state_d = ST_WAIT_LOCK;
            end
            ST_RUN:       if (!lock_s) state_d = ST_RST_PLL;
            ST_FAULT:     state_d = ST_FAULT;
            default:      state_d = ST_RST_PLL;
        endcase
    end

    always_comb begin
        pulse_d = ((state_q == ST_RST_PLL) && (state_d == ST_RST_PLL)) ? pulse_q + 1'b1 : '0;
        tmo_d   = (acquiring_q && acquiring_d) ? tmo_q + 1'b1 : '0;
        stab_d  = ((state_q == ST_STABLE) && (state_d == ST_STABLE)) ? stab_q + 1'b1 : '0;
        retry_d = retry_q;
        if (timeout && (retry_q != RETRY_LAST)) retry_d = retry_q + 1'b1;
        if (lost) retry_d = 2'd0;
        loss_d  = (lost && (loss_q != 8'hFF)) ? loss_q + 1'b1 : loss_q;
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q     <= ST_RST_PLL;
            pulse_q     <= '0;
            tmo_q       <= '0;
            stab_q      <= '0;
            retry_q     <= 2'd0;
            loss_q      <= 8'd0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            tmo_q       <= tmo_d;
            stab_q      <= stab_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
            sys_rst_q   <= (state_d != ST_RUN);
            locked_q    <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign pll_reset     = pll_reset_q;
    assign sys_rst       = sys_rst_q;
    assign locked        = locked_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - directed self-checking bench for pll_lock_ctrl
module tb_pll_lock_ctrl;

    logic       refclk = 1'b0;
    logic       reset  = 1'b1;
    logic       extlock = 1'b0;
    logic       pll_reset, sys_rst, locked, fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    pll_lock_ctrl #(
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (20),
        .LOCK_STABLE_CYC  (5),
        .RETRY_MAX        (2)
    ) dut (
        .refclk        (refclk),
        .reset         (reset),
        .extlock       (extlock),
        .pll_reset     (pll_reset),
        .sys_rst       (sys_rst),
        .locked        (locked),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    // cyc = n means we sit 1 time unit into cycle n; cycle 0 follows the last reset edge.
    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        extlock = 1'b0;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_locked(input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k <= budget; k++) begin
            if (locked === val) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if ({pll_reset, sys_rst, locked, fault, retry_cnt, lock_loss_cnt} !== 14'b1100_00_00000000) begin miscompares++; $display("FAIL reset_values: got %b want 1100_00_00000000", {pll_reset, sys_rst, locked, fault, retry_cnt, lock_loss_cnt}); end
    endtask

    task automatic test_clean_lock();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            run_to(c);
            vectors++; if (pll_reset !== (c < 4)) begin miscompares++; $display("FAIL clean_pll_reset_c%0d: got %b want %b", c, pll_reset, (c < 4)); end
        end
        run_to(6); extlock = 1'b1;
        run_to(13);
        vectors++; if ({locked, sys_rst} !== 2'b01) begin miscompares++; $display("FAIL clean_prerun_c13: got %b want 01", {locked, sys_rst}); end
        run_to(14);
        vectors++; if ({locked, sys_rst, pll_reset, retry_cnt} !== 5'b100_00) begin miscompares++; $display("FAIL clean_run_c14: got %b want 100_00", {locked, sys_rst, pll_reset, retry_cnt}); end
    endtask

    task automatic test_glitch();
        do_reset();
        run_to(6);  extlock = 1'b1;
        run_to(10); extlock = 1'b0;
        run_to(11); extlock = 1'b1;
        run_to(14);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL glitch_c14: got %b want 0", locked); end
        run_to(18);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL glitch_c18: got %b want 0", locked); end
        run_to(19);
        vectors++; if ({locked, sys_rst, retry_cnt} !== 4'b10_00) begin miscompares++; $display("FAIL glitch_run_c19: got %b want 10_00", {locked, sys_rst, retry_cnt}); end
    endtask

    task automatic test_timeout_boundary();
        do_reset();
        run_to(16); extlock = 1'b1;
        run_to(24);
        vectors++; if ({locked, pll_reset, retry_cnt} !== 4'b10_00) begin miscompares++; $display("FAIL tmo_run_wins_c24: got %b want 10_00", {locked, pll_reset, retry_cnt}); end
        do_reset();
        run_to(17); extlock = 1'b1;
        run_to(24);
        vectors++; if ({locked, pll_reset, retry_cnt} !== 4'b01_01) begin miscompares++; $display("FAIL tmo_late_c24: got %b want 01_01", {locked, pll_reset, retry_cnt}); end
    endtask

    task automatic test_timeout_retry();
        do_reset();
        run_to(23);
        vectors++; if ({pll_reset, retry_cnt} !== 3'b0_00) begin miscompares++; $display("FAIL retry_c23: got %b want 0_00", {pll_reset, retry_cnt}); end
        run_to(24);
        vectors++; if ({pll_reset, retry_cnt, fault} !== 4'b1_01_0) begin miscompares++; $display("FAIL retry_c24: got %b want 1_01_0", {pll_reset, retry_cnt, fault}); end
        run_to(27);
        vectors++; if (pll_reset !== 1'b1) begin miscompares++; $display("FAIL retry_c27: got %b want 1", pll_reset); end
        run_to(28);
        vectors++; if (pll_reset !== 1'b0) begin miscompares++; $display("FAIL retry_c28: got %b want 0", pll_reset); end
        run_to(47);
        vectors++; if ({fault, pll_reset} !== 2'b00) begin miscompares++; $display("FAIL fault_c47: got %b want 00", {fault, pll_reset}); end
        run_to(48);
        vectors++; if ({fault, pll_reset, sys_rst, locked} !== 4'b1110) begin miscompares++; $display("FAIL fault_c48: got %b want 1110", {fault, pll_reset, sys_rst, locked}); end
        for (int c = 49; c < 149; c++) begin
            run_to(c);
            vectors++; if ({fault, pll_reset, sys_rst, locked} !== 4'b1110) begin miscompares++; $display("FAIL fault_hold_c%0d: got %b want 1110", c, {fault, pll_reset, sys_rst, locked}); end
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        run_to(26); extlock = 1'b1;
        run_to(33);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL loss_prerun_c33: got %b want 0", locked); end
        run_to(34);
        vectors++; if ({locked, retry_cnt} !== 3'b1_01) begin miscompares++; $display("FAIL loss_run_c34: got %b want 1_01", {locked, retry_cnt}); end
        run_to(40); extlock = 1'b0;
        run_to(41); extlock = 1'b1;
        run_to(42);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_c42: got %b want 1", locked); end
        run_to(43);
        vectors++; if ({locked, sys_rst, pll_reset, retry_cnt, lock_loss_cnt} !== 13'b011_00_00000001) begin miscompares++; $display("FAIL loss_c43: got %b want 011_00_00000001", {locked, sys_rst, pll_reset, retry_cnt, lock_loss_cnt}); end
        run_to(46);
        vectors++; if (pll_reset !== 1'b1) begin miscompares++; $display("FAIL loss_pulse_c46: got %b want 1", pll_reset); end
        run_to(47);
        vectors++; if (pll_reset !== 1'b0) begin miscompares++; $display("FAIL loss_pulse_c47: got %b want 0", pll_reset); end
        run_to(52);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL relock_c52: got %b want 0", locked); end
        run_to(53);
        vectors++; if ({locked, lock_loss_cnt} !== 9'b1_00000001) begin miscompares++; $display("FAIL relock_c53: got %b want 1_00000001", {locked, lock_loss_cnt}); end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [7:0] exp_loss;
        exp_loss = 8'd1;
        for (int i = 2; i <= 260; i++) begin
            extlock = 1'b0;
            step();
            extlock = 1'b1;
            wait_locked(1'b0, 10, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL sat_drop_%0d: locked=%b after 10 cycles want 0", i, locked); end
            exp_loss = (exp_loss == 8'd255) ? 8'd255 : exp_loss + 8'd1;
            vectors++; if (lock_loss_cnt !== exp_loss) begin miscompares++; $display("FAIL sat_count_%0d: got %0d want %0d", i, lock_loss_cnt, exp_loss); end
            wait_locked(1'b1, 40, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL sat_relock_%0d: locked=%b after 40 cycles want 1", i, locked); end
        end
    endtask

    task automatic test_reset_mid();
        step();
        vectors++; if ({locked, lock_loss_cnt} !== 9'b1_11111111) begin miscompares++; $display("FAIL mid_prerun: got %b want 1_11111111", {locked, lock_loss_cnt}); end
        pulse_reset();
        vectors++; if ({pll_reset, sys_rst, locked, fault, retry_cnt, lock_loss_cnt} !== 14'b1100_00_00000000) begin miscompares++; $display("FAIL mid_run_reset: got %b want 1100_00_00000000", {pll_reset, sys_rst, locked, fault, retry_cnt, lock_loss_cnt}); end
        run_to(9);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL mid_restart_c9: got %b want 0", locked); end
        run_to(10);
        vectors++; if ({locked, sys_rst} !== 2'b10) begin miscompares++; $display("FAIL mid_restart_c10: got %b want 10", {locked, sys_rst}); end

        pulse_reset();
        run_to(2);
        pulse_reset();
        run_to(3);
        vectors++; if (pll_reset !== 1'b1) begin miscompares++; $display("FAIL mid_pulse_c3: got %b want 1", pll_reset); end
        run_to(4);
        vectors++; if (pll_reset !== 1'b0) begin miscompares++; $display("FAIL mid_pulse_c4: got %b want 0", pll_reset); end

        do_reset();
        run_to(48);
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL mid_fault_c48: got %b want 1", fault); end
        run_to(60);
        pulse_reset();
        vectors++; if ({pll_reset, sys_rst, locked, fault, retry_cnt, lock_loss_cnt} !== 14'b1100_00_00000000) begin miscompares++; $display("FAIL mid_fault_reset: got %b want 1100_00_00000000", {pll_reset, sys_rst, locked, fault, retry_cnt, lock_loss_cnt}); end
        run_to(4);
        vectors++; if ({pll_reset, fault} !== 2'b00) begin miscompares++; $display("FAIL mid_fault_restart_c4: got %b want 00", {pll_reset, fault}); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_glitch();
        test_timeout_boundary();
        test_timeout_retry();
        test_lock_loss();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
